// File: rtl/led_status_ctrl.sv
// Multi-channel LED status driver: per-channel off / stretch / counted blink / steady modes.
// Optional idle heartbeat on channel 0 is compiled in when LED_HEARTBEAT_EN is defined.

module led_status_chan #(
   parameter int CNT_W       = 24,
   parameter int HOLD_CYCLES = 65536,
   parameter int PEND_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       event_i,
   input  logic [1:0] mode_i,
   output logic       lit_d_o,
   output logic       idle_d_o
);
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_LIT       = 2'd1;
   localparam logic [1:0] S_BLINK_ON  = 2'd2;
   localparam logic [1:0] S_BLINK_OFF = 2'd3;

   localparam logic [1:0] M_OFF     = 2'b00;
   localparam logic [1:0] M_STRETCH = 2'b01;
   localparam logic [1:0] M_STEADY  = 2'b11;

   localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic [1:0]        mode_q, mode_d;
   logic              hold_done;
   logic [PEND_W-1:0] pend_up;

   assign hold_done = (cnt_q == HOLD_LAST);
   assign pend_up   = (event_i && (pend_q != PEND_MAX)) ? pend_q + 1'b1 : pend_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      mode_d  = mode_q;
      // Disable and mode changes both flush the channel and drop that cycle's event.
      if (!enable || (mode_i != mode_q)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         pend_d  = '0;
         mode_d  = mode_i;
      end else begin
         case (mode_q)
            M_OFF: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               pend_d  = '0;
            end
            M_STEADY: begin
               state_d = S_LIT;
               cnt_d   = '0;
               pend_d  = '0;
            end
            M_STRETCH: begin
               pend_d = '0;
               if (event_i) begin
                  state_d = S_LIT;
                  cnt_d   = '0;
               end else if (state_q == S_LIT) begin
                  if (hold_done) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               case (state_q)
                  S_BLINK_ON: begin
                     pend_d = pend_up;
                     if (hold_done) begin
                        state_d = S_BLINK_OFF;
                        cnt_d   = '0;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  S_BLINK_OFF: begin
                     pend_d = pend_up;
                     if (hold_done) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  default: begin
                     // A blink start with a coincident event nets to no pending change.
                     cnt_d = '0;
                     if (pend_q != '0) begin
                        state_d = S_BLINK_ON;
                        pend_d  = event_i ? pend_q : pend_q - 1'b1;
                     end else begin
                        state_d = S_IDLE;
                        pend_d  = pend_up;
                     end
                  end
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         mode_q  <= M_OFF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         mode_q  <= mode_d;
      end
   end

   assign lit_d_o  = (state_d == S_LIT) || (state_d == S_BLINK_ON);
   assign idle_d_o = (state_d == S_IDLE);
endmodule

module led_status_ctrl #(
   parameter int NUM_LEDS         = 4,
   parameter int CNT_W            = 24,
   parameter int HOLD_CYCLES      = 65536,
   parameter int PEND_W           = 4,
   parameter int HEARTBEAT_CYCLES = 8388608
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [NUM_LEDS-1:0]   event_i,
   input  logic [2*NUM_LEDS-1:0] mode_i,
   output logic [NUM_LEDS-1:0]   led,
   output logic                  active
);
   logic [NUM_LEDS-1:0] lit_d;
   logic [NUM_LEDS-1:0] idle_d;
   logic [NUM_LEDS-1:0] led_d;

   led_status_chan #(
      .CNT_W       (CNT_W),
      .HOLD_CYCLES (HOLD_CYCLES),
      .PEND_W      (PEND_W)
   ) u_chan [NUM_LEDS-1:0] (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .event_i  (event_i),
      .mode_i   (mode_i),
      .lit_d_o  (lit_d),
      .idle_d_o (idle_d)
   );

`ifdef LED_HEARTBEAT_EN
   localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

   logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
   logic            hb_q, hb_d;

   always_comb begin
      hb_cnt_d = hb_cnt_q;
      hb_d     = hb_q;
      if (!enable) begin
         hb_cnt_d = '0;
         hb_d     = 1'b0;
      end else if (hb_cnt_q == HB_LAST) begin
         hb_cnt_d = '0;
         hb_d     = ~hb_q;
      end else begin
         hb_cnt_d = hb_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_cnt_q <= '0;
         hb_q     <= 1'b0;
      end else begin
         hb_cnt_q <= hb_cnt_d;
         hb_q     <= hb_d;
      end
   end

   // Heartbeat only shows on an idle stretch-mode channel 0 and never counts as activity.
   always_comb begin
      led_d    = lit_d;
      led_d[0] = lit_d[0] | (hb_d & idle_d[0] & (mode_i[1:0] == 2'b01));
   end
`else
   logic unused_idle;
   assign unused_idle = ^idle_d;
   assign led_d       = lit_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led    <= '0;
         active <= 1'b0;
      end else begin
         led    <= led_d;
         active <= |lit_d;
      end
   end
endmodule
